rollover_logger: RTL
====================

ROLLOVER_LOGGER -- requirements
Module: rollover_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TS_W, default 16, timestamp width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port srst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port en  input  1  capture enable.
REQ-006 SHALL have port rollover  input  1  wrap indication from upstream counter, sampled every clk.
REQ-007 SHALL have port up  input  1  counter direction at the wrap (1=up overflow FF->00, 0=down underflow 00->FF).
REQ-008 SHALL have port count  input  8  upstream counter value; logged with each event.
REQ-009 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-010 SHALL have port clr_ovf  input  1  clears drop statistics.
REQ-011 SHALL have port out_valid  output  1  head entry present.
REQ-012 SHALL have port out_dir  output  1  head entry direction.
REQ-013 SHALL have port out_count  output  8  head entry count value.
REQ-014 SHALL have port out_ts  output  TS_W  head entry timestamp.
REQ-015 SHALL have port fill  output  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
REQ-016 SHALL have port ovf  output  1  sticky: at least one event dropped.
REQ-017 SHALL have port drop_cnt  output  8  dropped events, saturating.

Function
REQ-018 SHALL run a free-running TS_W-bit timestamp, +1 every clk, wrapping all-ones -> 0, independent of en.
REQ-019 SHALL treat each cycle with rollover=1 and en=1 as one event (level-sampled; consecutive high cycles = consecutive events).
REQ-020 SHALL form entry {dir=up, count, ts=timestamp value before that edge's increment}.
REQ-021 SHALL push the event when fill<DEPTH, or when fill==DEPTH and a pop occurs the same cycle.
REQ-022 SHALL pop when out_valid=1 and out_ready=1; out_* SHALL advance to next entry on the following cycle.
REQ-023 SHALL drive out_valid = (fill!=0); out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 SHALL give 1-cycle latency: event at edge N -> out_valid=1 after edge N when previously empty (no bypass).
REQ-025 SHALL on simultaneous push and pop keep fill unchanged, including at fill==0 impossible case (no pop when empty) and fill==DEPTH.
REQ-026 SHALL preserve strict FIFO order; pointers wrap modulo DEPTH.
REQ-027 SHALL on an event with fill==DEPTH and no pop drop it, set ovf=1, increment drop_cnt, saturating at 255.
REQ-028 SHALL on clr_ovf=1 clear ovf and drop_cnt; clr_ovf with simultaneous drop SHALL yield ovf=1, drop_cnt=1.
REQ-029 SHALL ignore rollover while en=0; en SHALL not affect pop, timestamp or stored entries.
REQ-030 SHALL drive out_* = 0 when fill==0.

Reset
REQ-031 SHALL on srst_n=0 immediately (no clock) force: timestamp=0, fill=0, out_valid=0, out_dir=0, out_count=0, out_ts=0, ovf=0, drop_cnt=0, pointers=0.
REQ-032 SHALL discard all stored entries on reset mid-operation; no event captured in any cycle where srst_n=0 at the edge.
REQ-033 SHALL resume on first rising edge after srst_n deasserts, timestamp counting from 0.

Verification
REQ-034 Reset 3 cycles, en=1, rollover=1 one cycle with up=1, count=00 at ts=5, out_ready=0 -> next cycle out_valid=1, out_dir=1, out_count=00, out_ts=5, fill=1.
REQ-035 out_ready=0, 6 consecutive rollover cycles at ts=10..15 -> fill=4, ts 10..13 stored, ovf=1, drop_cnt=2; drain with out_ready=1 -> out_ts 10,11,12,13 on consecutive cycles then out_valid=0.
REQ-036 fill=4, rollover=1 and out_ready=1 same cycle -> fill stays 4, ovf stays 0, new entry appended at tail.
REQ-037 drop_cnt=255, further drop -> drop_cnt=255; clr_ovf=1 with drop same cycle -> ovf=1, drop_cnt=1.
REQ-038 en=0 with rollover=1 for 5 cycles -> fill=0, out_valid=0; timestamp still advances by 5.
REQ-039 fill=3, srst_n pulsed low mid-cycle -> out_valid=0, fill=0, ovf=0 immediately; next event after release logs ts starting from 0.

Source files
------------

// File: rtl/rollover_logger.sv
// rollover_logger
//   Captures counter wrap events (direction, counter value, timestamp) into a
//   small FIFO for a downstream consumer. Events that find the FIFO full are
//   dropped and counted in sticky/saturating statistics.
//
// Parameters
//   DEPTH  FIFO entries (power of 2, >= 2)
//   TS_W   free-running timestamp width
//
// Ports
//   clk        sole clock, rising edge
//   srst_n     asynchronous active-low reset
//   en         capture enable
//   rollover   wrap indication, level-sampled every cycle
//   up         wrap direction (1 = overflow, 0 = underflow)
//   count      upstream counter value logged with each event
//   out_ready  consumer accepts the head entry
//   clr_ovf    clears ovf and drop_cnt
//   out_valid  head entry present
//   out_dir    head entry direction
//   out_count  head entry counter value
//   out_ts     head entry timestamp
//   fill       occupied entries, 0..DEPTH
//   ovf        sticky: at least one event dropped
//   drop_cnt   dropped events, saturating at 255
module rollover_logger #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     srst_n,
  input  logic                     en,
  input  logic                     rollover,
  input  logic                     up,
  input  logic [7:0]               count,
  input  logic                     out_ready,
  input  logic                     clr_ovf,
  output logic                     out_valid,
  output logic                     out_dir,
  output logic [7:0]               out_count,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     ovf,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  logic [TS_W-1:0] ts;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic            mem_dir [DEPTH];
  logic [7:0]      mem_cnt [DEPTH];
  logic [TS_W-1:0] mem_ts  [DEPTH];

  logic evt;
  logic pop;
  logic full;
  logic push;
  logic drop;

  assign evt  = rollover & en;
  assign pop  = (fill != '0) & out_ready;
  assign full = (fill == FULL);
  // A full FIFO still accepts an event when the head leaves in the same cycle.
  assign push = evt & (~full | pop);
  assign drop = evt & full & ~pop;

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      ts     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Storage needs no reset: fill and the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (push && srst_n) begin
      mem_dir[wr_ptr] <= up;
      mem_cnt[wr_ptr] <= count;
      mem_ts[wr_ptr]  <= ts;
    end
  end

  // A clear coinciding with a drop keeps that drop as the first new one.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      ovf      <= drop;
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_dir   = 1'b0;
    out_count = '0;
    out_ts    = '0;
    if (fill != '0) begin
      out_valid = 1'b1;
      out_dir   = mem_dir[rd_ptr];
      out_count = mem_cnt[rd_ptr];
      out_ts    = mem_ts[rd_ptr];
    end
  end

endmodule
